sync_prod_window_acc: RTL

SYNC_PROD_WINDOW_ACC -- requirements
Module: sync_prod_window_acc

---
 rtl/sync_pkg.sv | 20 ++
 rtl/sync_acc_delay_line.sv | 27 ++
 rtl/sync_prod_window_acc.sv | 111 +++++++++++
 3 files changed

// File: rtl/sync_pkg.sv
// Shared definitions for the windowed product accumulator: default widths,
// accumulator width derivation and the fill/run state encoding.
package sync_pkg;

    localparam int unsigned PROD_W_DEF = 30;
    localparam int unsigned WIN_DEF    = 16;

    // Summing WIN signed PROD_W-bit samples needs log2(WIN) extra bits.
    function automatic int unsigned acc_w_of(input int unsigned prod_w, input int unsigned win);
        return prod_w + $clog2(win);
    endfunction

    localparam int unsigned ACC_W_DEF = acc_w_of(PROD_W_DEF, WIN_DEF);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sync_acc_delay_line.sv
// Circular delay line of DEPTH samples: the entry at ptr_i is the oldest
// sample and is read combinationally before being overwritten on a write.
module sync_acc_delay_line
    import sync_pkg::*;
#(
    parameter  int unsigned W     = PROD_W_DEF,
    parameter  int unsigned DEPTH = WIN_DEF,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] ptr_i,
    input  logic [W-1:0]  wr_data_i,
    output logic [W-1:0]  rd_data_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[ptr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[ptr_i];

endmodule

// File: rtl/sync_prod_window_acc.sv
// Sliding-window sum of the last WIN accepted signed products, with a
// valid/ready handshake on both sides and one cycle of latency.
module sync_prod_window_acc
    import sync_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned WIN    = WIN_DEF,
    parameter int unsigned ACC_W  = acc_w_of(PROD_W, WIN)
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              flush,
    input  logic [PROD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned      PTR_W = $clog2(WIN);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(WIN - 1);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic [PROD_W-1:0]  oldest;
    logic [ACC_W-1:0]   in_ext, oldest_ext, sum_upd;

    assign in_ready = (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    sync_acc_delay_line #(
        .W     (PROD_W),
        .DEPTH (WIN)
    ) u_delay (
        .clk_i     (ap_clk),
        .wr_en_i   (accept),
        .ptr_i     (ptr_q),
        .wr_data_i (in_data),
        .rd_data_o (oldest)
    );

    // Buffer contents are stale during FILL (after reset or flush), so the
    // subtracted term is forced to zero until the window is full.
    assign in_ext     = {{(ACC_W - PROD_W){in_data[PROD_W-1]}}, in_data};
    assign oldest_ext = (state_q == RUN) ? {{(ACC_W - PROD_W){oldest[PROD_W-1]}}, oldest} : '0;
    assign sum_upd    = sum_q + in_ext - oldest_ext;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            state_d     = FILL;
            ptr_d       = '0;
            cnt_d       = '0;
            sum_d       = '0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            sum_d = sum_upd;
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
            if (state_q == FILL) begin
                cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PTR_W'(1);
                if (cnt_q == LAST) begin
                    state_d = RUN;
                end
            end
            // Acceptance implies any pending output was just taken, so a
            // new result can replace it with no bubble.
            if (state_q == RUN || cnt_q == LAST) begin
                out_valid_d = 1'b1;
                out_data_d  = sum_upd;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= FILL;
            ptr_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule
